// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the execute stage: opcode/funct3 encodings
// and the immediate extraction helpers.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_RIMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/rv32i_alu_comb.sv
// Combinational ALU and branch comparator. Only R/Rimm honour funct3 for the
// ALU; everything else adds. Branch compare always uses a (rs1) vs b (rs2).
module rv32i_alu_comb
    import rv32i_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] inst,
    output logic [31:0] alu_out,
    output logic        take_b
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic [4:0] shamt;
    logic       is_r;
    logic       unused_inst_bits;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign alt    = inst[30];
    assign shamt  = b[4:0];
    assign is_r   = (opcode == OP_R);
    assign unused_inst_bits = &{1'b0, inst[31], inst[29:15], inst[11:7]};

    always_comb begin
        alu_out = a + b;
        if (is_r || opcode == OP_RIMM) begin
            case (funct3)
                F3_ADD:  alu_out = (is_r && alt) ? a - b : a + b;
                F3_SLL:  alu_out = a << shamt;
                F3_SLT:  alu_out = {31'b0, $signed(a) < $signed(b)};
                F3_SLTU: alu_out = {31'b0, a < b};
                F3_XOR:  alu_out = a ^ b;
                F3_SR:   alu_out = alt ? $unsigned($signed(a) >>> shamt) : a >> shamt;
                F3_OR:   alu_out = a | b;
                default: alu_out = a & b;
            endcase
        end
    end

    always_comb begin
        take_b = 1'b0;
        if (opcode == OP_B) begin
            case (funct3)
                F3_BEQ:  take_b = (a == b);
                F3_BNE:  take_b = (a != b);
                F3_BLT:  take_b = ($signed(a) < $signed(b));
                F3_BGE:  take_b = ($signed(a) >= $signed(b));
                F3_BLTU: take_b = (a < b);
                F3_BGEU: take_b = (a >= b);
                default: take_b = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_exec_stage.sv
// RV32I execute stage: immediate decode, operand select, ALU, branch target,
// all registered with one cycle of latency.
module rv32i_exec_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [31:0] imm,
    output logic        take_b,
    output logic [31:0] addr
);

    logic [6:0]  opcode;
    logic [31:0] imm_d, imm_q;
    logic [31:0] op_a, op_b, base, alu_out, sum;
    logic        alu_take_b;
    logic [31:0] result_d, result_q;
    logic [31:0] addr_d, addr_q;
    logic        take_b_d, take_b_q;
    logic        out_valid_d, out_valid_q;

    assign opcode = inst[6:0];

    always_comb begin
        case (opcode)
            OP_LOAD, OP_RIMM, OP_JALR: imm_d = imm_i(inst);
            OP_S:                      imm_d = imm_s(inst);
            OP_B:                      imm_d = imm_b(inst);
            OP_LUI, OP_AUIPC:          imm_d = imm_u(inst);
            OP_JAL:                    imm_d = imm_j(inst);
            default:                   imm_d = 32'd0;
        endcase
    end

    always_comb begin
        op_a = rs1;
        if (opcode == OP_JAL || opcode == OP_JALR || opcode == OP_AUIPC)
            op_a = pc;
        op_b = 32'd4;
        if (opcode == OP_R || opcode == OP_B)
            op_b = rs2;
        else if (opcode == OP_RIMM || opcode == OP_AUIPC)
            op_b = imm_d;
    end

    rv32i_alu_comb u_alu (
        .a       (op_a),
        .b       (op_b),
        .inst    (inst),
        .alu_out (alu_out),
        .take_b  (alu_take_b)
    );

    // Branch/JAL targets are pc-relative; loads, stores and JALR are rs1-relative.
    always_comb begin
        base = (opcode == OP_JAL || opcode == OP_B) ? pc : rs1;
        sum  = base + imm_d;
        addr_d = (opcode == OP_JALR) ? {sum[31:1], 1'b0} : sum;
    end

    always_comb begin
        out_valid_d = in_valid;
        result_d    = result_q;
        take_b_d    = take_b_q;
        addr_d_hold: begin end
        if (in_valid) begin
            result_d = (opcode == OP_LUI) ? imm_d : alu_out;
            take_b_d = alu_take_b;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            imm_q       <= 32'd0;
            take_b_q    <= 1'b0;
            addr_q      <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            take_b_q    <= take_b_d;
            if (in_valid) begin
                imm_q  <= imm_d;
                addr_q <= addr_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign imm       = imm_q;
    assign take_b    = take_b_q;
    assign addr      = addr_q;

endmodule

// File: tb/tb_rv32i_exec_stage.sv
// Bench for rv32i_exec_stage: directed vectors plus randomized instructions
// checked against a behavioural model of the RV32I execute rules.
module tb_rv32i_exec_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0, pc = '0, rs1 = '0, rs2 = '0;
    logic        out_valid, take_b;
    logic [31:0] result, imm, addr;

    int n_chk = 0;
    int n_err = 0;

    logic        e_valid = 1'b0, e_take = 1'b0;
    logic [31:0] e_result = '0, e_imm = '0, e_addr = '0;

    rv32i_exec_stage dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .inst      (inst),
        .pc        (pc),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .result    (result),
        .imm       (imm),
        .take_b    (take_b),
        .addr      (addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, e_valid});
        chk({tag, ".result"},    result, e_result);
        chk({tag, ".imm"},       imm, e_imm);
        chk({tag, ".take_b"},    {31'b0, take_b}, {31'b0, e_take});
        chk({tag, ".addr"},      addr, e_addr);
    endtask

    // Reference model: executes one instruction straight from the ISA rules.
    task automatic model(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] x1, input logic [31:0] x2);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] im, bv, r, ad;
        logic        tk;
        int          sh;
        op = i[6:0];
        f3 = i[14:12];
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: im = {{20{i[31]}}, i[31:20]};
            7'b0100011: im = {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: im = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'b0110111, 7'b0010111: im = {i[31:12], 12'b0};
            7'b1101111: im = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: im = 32'd0;
        endcase
        tk = 1'b0;
        case (op)
            7'b0110011, 7'b0010011: begin
                bv = (op == 7'b0110011) ? x2 : im;
                sh = int'(bv % 32);
                case (f3)
                    3'd0: r = (op == 7'b0110011 && i[30]) ? x1 - bv : x1 + bv;
                    3'd1: r = x1 << sh;
                    3'd2: r = ($signed(x1) < $signed(bv)) ? 32'd1 : 32'd0;
                    3'd3: r = (x1 < bv) ? 32'd1 : 32'd0;
                    3'd4: r = x1 ^ bv;
                    3'd5: r = i[30] ? 32'($signed(x1) >>> sh) : x1 >> sh;
                    3'd6: r = x1 | bv;
                    default: r = x1 & bv;
                endcase
            end
            7'b0110111: r = im;
            7'b0010111: r = p + im;
            7'b1101111, 7'b1100111: r = p + 32'd4;
            7'b1100011: begin
                r = x1 + x2;
                case (f3)
                    3'd0: tk = (x1 == x2);
                    3'd1: tk = (x1 != x2);
                    3'd4: tk = ($signed(x1) < $signed(x2));
                    3'd5: tk = ($signed(x1) >= $signed(x2));
                    3'd6: tk = (x1 < x2);
                    3'd7: tk = (x1 >= x2);
                    default: tk = 1'b0;
                endcase
            end
            default: r = x1 + 32'd4;
        endcase
        ad = ((op == 7'b1101111 || op == 7'b1100011) ? p : x1) + im;
        if (op == 7'b1100111) ad[0] = 1'b0;
        e_result = r;
        e_imm    = im;
        e_take   = tk;
        e_addr   = ad;
    endtask

    // Drive one cycle of inputs (called just after a rising edge), then check.
    task automatic apply(input string tag, input logic v, input logic [31:0] i,
                         input logic [31:0] p, input logic [31:0] x1, input logic [31:0] x2);
        in_valid = v; inst = i; pc = p; rs1 = x1; rs2 = x2;
        if (v) model(i, p, x1, x2);
        e_valid = v;
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    localparam int NOPS = 10;
    logic [6:0] ops [NOPS] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011};

    initial begin
        logic [31:0] ri;
        #1;
        chk_all("reset_async");
        @(posedge clk);
        #1;
        chk_all("reset_held");
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_reset_idle");

        apply("add",  1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);
        chk("add.val", result, 32'd12);
        apply("sub",  1'b1, 32'h402081B3, 32'h0, 32'd5, 32'd7);
        chk("sub.val", result, 32'hFFFFFFFE);
        apply("srai", 1'b1, 32'h4040D093, 32'h0, 32'h80000000, 32'h0);
        chk("srai.val", result, 32'hF8000000);
        apply("srli", 1'b1, 32'h0040D093, 32'h0, 32'h80000000, 32'h0);
        chk("srli.val", result, 32'h08000000);
        apply("blt",  1'b1, 32'h0020C463, 32'h40, 32'hFFFFFFFF, 32'd1);
        chk("blt.take", {31'b0, take_b}, 32'd1);
        chk("blt.addr", addr, 32'h48);
        apply("bltu", 1'b1, 32'h0020E463, 32'h40, 32'hFFFFFFFF, 32'd1);
        chk("bltu.take", {31'b0, take_b}, 32'd0);
        chk("bltu.addr", addr, 32'h48);
        apply("jalr", 1'b1, 32'h004100E7, 32'h100, 32'h1001, 32'h0);
        chk("jalr.result", result, 32'h104);
        chk("jalr.addr", addr, 32'h1004);
        apply("lui",  1'b1, 32'h123450B7, 32'h0, 32'h0, 32'h0);
        chk("lui.val", result, 32'h12345000);
        apply("auipc", 1'b1, 32'h12345097, 32'h10, 32'h0, 32'h0);
        chk("auipc.val", result, 32'h12345010);
        apply("hold0", 1'b0, $urandom, $urandom, $urandom, $urandom);
        apply("hold1", 1'b0, 32'h402081B3, 32'h40, 32'h5, 32'h7);
        chk("hold.val", result, 32'h12345010);

        // Asynchronous reset in mid-cycle clears everything before the next edge.
        #2 resetn = 1'b0;
        #1;
        e_valid = 1'b0; e_result = '0; e_imm = '0; e_take = 1'b0; e_addr = '0;
        chk_all("reset_mid");
        #1 resetn = 1'b1;

        for (int n = 0; n < 300; n++) begin
            ri = $urandom;
            if ($urandom_range(0, 9) != 0) ri[6:0] = ops[$urandom_range(0, NOPS - 1)];
            if ($urandom_range(0, 3) == 0) ri[14:12] = 3'd5;
            apply("rand", ($urandom_range(0, 4) != 0), ri, $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom,
                  ($urandom_range(0, 3) == 0) ? ri ^ ri : $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
